// File: rtl/pattern_detector.sv
// pattern_detector: serial bit-pattern matcher with care mask, overlap control and saturating match counter
// ports: clk; rst async active-high; x serial bit; en sample enable; load captures pat_in/mask_in;
//        clr_cnt clears match_cnt; z registered match pulse; match_cnt saturating count; busy while fill < N
module pattern_detector #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN_INIT = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic [N-1:0]     mask_in,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);
  logic [N-1:0] win, pat, mask, win_nxt;
  logic [FW-1:0] fill, fill_inc;
  logic accept, hit;
  assign accept   = en & ~load;
  assign win_nxt  = {win[N-2:0], x};
  assign fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
  assign hit      = accept && fill_inc == FULL && ((win_nxt ^ pat) & mask) == '0;
  assign busy     = fill < FULL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z         <= 1'b0;
      match_cnt <= '0;
      win       <= '0;
      fill      <= '0;
      pat       <= PATTERN_INIT;
      mask      <= '1;
    end else begin
      z         <= hit;
      match_cnt <= clr_cnt ? '0 : (hit && ~&match_cnt) ? match_cnt + 1'b1 : match_cnt;
      if (load) begin
        pat  <= pat_in;
        mask <= mask_in;
        win  <= '0;
        fill <= '0;
      end else if (en) begin
        win  <= win_nxt;
        // non-overlapping mode restarts the fill so the next match needs N fresh bits
        fill <= (hit && !OVERLAP) ? '0 : fill_inc;
      end
    end
  end
endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: randomized and directed check of pattern_detector against a sample-history model
module tb_pattern_detector;
  localparam int N = 4;
  localparam logic [3:0] PI = 4'b1011;
  logic clk = 1'b0, rst = 1'b1, x = 1'b0, en = 1'b0, load = 1'b0, clr_cnt = 1'b0;
  logic [3:0] pat_in = '0, mask_in = '0;
  logic z1, z0, z2, b1, b0, b2;
  logic [7:0] c1, c0;
  logic [1:0] c2;
  int total = 0, bad = 0;
  bit hist[3][$];
  logic [3:0] mpat, mmask;
  int mcnt[3];
  bit mz[3];
  int ovl[3] = '{1, 0, 1};
  int cmax[3] = '{255, 255, 3};
  always #5 clk = ~clk;
  pattern_detector d1 (.clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .mask_in(mask_in), .clr_cnt(clr_cnt), .z(z1), .match_cnt(c1), .busy(b1));
  pattern_detector #(.OVERLAP(0)) d0 (.clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .mask_in(mask_in), .clr_cnt(clr_cnt), .z(z0), .match_cnt(c0), .busy(b0));
  pattern_detector #(.CNT_W(2)) d2 (.clk(clk), .rst(rst), .x(x), .en(en), .load(load), .pat_in(pat_in),
    .mask_in(mask_in), .clr_cnt(clr_cnt), .z(z2), .match_cnt(c2), .busy(b2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit win_ok(input int i);
    for (int k = 0; k < N; k++)
      if (mmask[k] && hist[i][N-1-k] != mpat[k]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      mcnt[i] = 0;
      mz[i] = 1'b0;
    end
    mpat = PI;
    mmask = '1;
  endtask
  task automatic mstep(input bit xi, input bit ei, input bit li, input bit ci, input logic [3:0] pi, input logic [3:0] mi);
    for (int i = 0; i < 3; i++) begin
      mz[i] = 1'b0;
      if (li) hist[i].delete();
      else if (ei) begin
        hist[i].push_back(xi);
        if (hist[i].size() > N) void'(hist[i].pop_front());
        if (hist[i].size() == N && win_ok(i)) begin
          mz[i] = 1'b1;
          if (ovl[i] == 0) hist[i].delete();
        end
      end
      if (ci) mcnt[i] = 0;
      else if (mz[i] && mcnt[i] < cmax[i]) mcnt[i]++;
    end
    if (li) begin
      mpat = pi;
      mmask = mi;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".z_ovl"}, 32'(z1), 32'(mz[0]));
    chk({tag, ".z_novl"}, 32'(z0), 32'(mz[1]));
    chk({tag, ".z_cnt2"}, 32'(z2), 32'(mz[2]));
    chk({tag, ".cnt_ovl"}, 32'(c1), mcnt[0]);
    chk({tag, ".cnt_novl"}, 32'(c0), mcnt[1]);
    chk({tag, ".cnt_cnt2"}, 32'(c2), mcnt[2]);
    chk({tag, ".busy_ovl"}, 32'(b1), 32'(hist[0].size() < N));
    chk({tag, ".busy_novl"}, 32'(b0), 32'(hist[1].size() < N));
    chk({tag, ".busy_cnt2"}, 32'(b2), 32'(hist[2].size() < N));
  endtask
  task automatic step(input bit xi, input bit ei, input bit li, input bit ci,
                      input logic [3:0] pi, input logic [3:0] mi, input string tag);
    x = xi; en = ei; load = li; clr_cnt = ci; pat_in = pi; mask_in = mi;
    @(posedge clk);
    mstep(xi, ei, li, ci, pi, mi);
    #1 check_all(tag);
  endtask
  task automatic feed(input string tag, input logic [15:0] bits, input int len);
    for (int k = len - 1; k >= 0; k--) step(bits[k], 1'b1, 1'b0, 1'b0, '0, '0, tag);
  endtask
  task automatic do_load(input logic [3:0] p, input logic [3:0] m, input string tag);
    step(1'b1, 1'b1, 1'b1, 1'b0, p, m, tag);
  endtask
  task automatic do_rst(input string tag);
    @(negedge clk);
    x = 1'b1; en = 1'b1; load = 1'b0; clr_cnt = 1'b0;
    #2 rst = 1'b1;
    #1 mreset();
    check_all(tag);
    @(posedge clk);
    #1 check_all({tag, "_hold"});
    @(negedge clk);
    rst = 1'b0; x = 1'b0; en = 1'b0;
  endtask
  initial begin
    bit l;
    logic [3:0] m;
    #1 mreset();
    check_all("por");
    @(negedge clk) rst = 1'b0;
    feed("basic", 16'b10110010, 8);
    do_rst("r1");
    feed("ovl", 16'b1011011, 7);
    do_load(4'b1001, 4'b1001, "ld1001");
    feed("mask", 16'b11111001, 8);
    do_load(4'b1111, 4'b1111, "ld1111");
    feed("sat", 16'b111111, 6);
    step(1'b1, 1'b1, 1'b0, 1'b1, '0, '0, "clr_hit");
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, "en_off");
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, "clr_en_off");
    feed("after_gap", 16'b1, 1);
    do_load(4'b0000, 4'b0000, "ld_dc");
    feed("dontcare", 16'b0110101, 7);
    do_rst("r2");
    feed("pre", 16'b101, 3);
    do_rst("r3");
    feed("post", 16'b11011, 5);
    feed("pre_ld", 16'b101, 3);
    do_load(4'b0110, 4'b1111, "ld_same_edge");
    feed("new_pat", 16'b0110110, 7);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(99) == 0) do_rst("rnd_rst");
      else begin
        l = $urandom_range(19) == 0;
        m = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) & 4'($urandom_range(15)) : 4'hf;
        step(1'($urandom_range(1)), $urandom_range(9) < 8, l, $urandom_range(24) == 0,
             4'($urandom_range(15)), m, "rnd");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
